pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after start.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  run enable; low forces IDLE.
REQ-006 pc_i  in  32  current PC register value.
REQ-007 dmem_stall_i  in  1  data memory busy; whole pipeline freezes.
REQ-008 idex_memread_i  in  1  instruction in EX is a load.
REQ-009 idex_rt_i  in  5  load destination register in EX.
REQ-010 ifid_rs_i, ifid_rt_i  in  5 each  source registers of instruction in ID.
REQ-011 branch_taken_i  in  1  branch in ID resolved taken.
REQ-012 branch_target_i  in  32  branch target.
REQ-013 jump_i  in  1  jump in ID.
REQ-014 jump_target_i  in  32  jump target.
REQ-015 pc_next_o  out  32  next PC value to PC register.
REQ-016 pc_stall_o  out  1  hold PC register.
REQ-017 ifid_stall_o  out  1  hold IF/ID register.
REQ-018 ifid_flush_o  out  1  zero IF/ID register.
REQ-019 idex_bubble_o  out  1  insert NOP into ID/EX.
REQ-020 freeze_o  out  1  hold every pipeline register.
REQ-021 state_o  out  2  FSM state: IDLE=0, BOOT=1, RUN=2, MEMWAIT=3.
REQ-022 stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-023 State register SHALL be one of IDLE, BOOT, RUN, MEMWAIT, registered; all other outputs combinational from state and inputs except counters (registered).
REQ-024 IDLE: pc_next_o=RESET_VECTOR, pc_stall_o=0, ifid_flush_o=1, all other controls 0; start_i=1 -> BOOT next cycle.
REQ-025 BOOT: pc_next_o=RESET_VECTOR, ifid_flush_o=1, pc_stall_o=0; always -> RUN next cycle (lasts exactly 1 cycle).
REQ-026 RUN priority, highest first: dmem_stall_i, load-use, jump, branch, sequential.
REQ-027 RUN with dmem_stall_i=1: freeze_o=1, pc_stall_o=1, ifid_stall_o=1, pc_next_o=pc_i, no flush/bubble; -> MEMWAIT.
REQ-028 MEMWAIT: same outputs as REQ-027 while dmem_stall_i=1; dmem_stall_i=0 -> RUN next cycle, outputs in that MEMWAIT cycle revert to RUN decode (no lost cycle).
REQ-029 Load-use: idex_memread_i=1 and idex_rt_i!=0 and idex_rt_i equals ifid_rs_i or ifid_rt_i -> pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1, pc_next_o=pc_i; jump/branch in same cycle SHALL be ignored (re-evaluated next cycle).
REQ-030 Jump: pc_next_o=jump_target_i, ifid_flush_o=1.
REQ-031 Branch taken (no jump): pc_next_o=branch_target_i, ifid_flush_o=1.
REQ-032 Otherwise: pc_next_o=pc_i+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-033 start_i=0 in any state SHALL force IDLE next cycle, including mid-MEMWAIT.
REQ-034 stall_cnt_o SHALL increment by 1 each cycle pc_stall_o=1 in BOOT/RUN/MEMWAIT; flush_cnt_o SHALL increment each cycle ifid_flush_o=1 in RUN; both saturate at all-ones, never wrap.
REQ-035 Counters SHALL hold (not clear) when returning to IDLE.

Reset
REQ-036 rst_i=1 at a clock edge SHALL set state to IDLE and both counters to 0, overriding start_i and all other inputs.
REQ-037 While rst_i=1, outputs SHALL equal IDLE values (pc_next_o=RESET_VECTOR, ifid_flush_o=1, others 0).
REQ-038 Reset asserted mid-MEMWAIT SHALL take effect on the next edge regardless of dmem_stall_i.

Verification
REQ-039 Boot: rst 2 cycles, start_i=1 -> state 0,1,2; pc_next_o=0 in BOOT, then pc_i+4 with pc_i=0 -> 4.
REQ-040 Load-use: RUN, idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, branch_taken_i=1 -> one cycle pc_stall_o=1, idex_bubble_o=1, ifid_flush_o=0, pc_next_o=pc_i; stall_cnt_o +1.
REQ-041 Branch vs jump: jump_i=1 (target 32'h40), branch_taken_i=1 (target 32'h80) -> pc_next_o=32'h40, ifid_flush_o=1, flush_cnt_o +1.
REQ-042 Memory stall: dmem_stall_i high 3 cycles from RUN -> states 3,3,3 then 2; freeze_o=1 for exactly 3 cycles; stall_cnt_o +3.
REQ-043 Wrap/saturation: pc_i=32'hFFFF_FFFC -> pc_next_o=0; CNT_W=4, 20 stall cycles -> stall_cnt_o=4'hF.
REQ-044 Abort: start_i=0 during MEMWAIT -> IDLE next cycle; rst_i=1 in RUN -> IDLE and counters 0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencing and hazard control for a 5-stage pipeline: boot FSM, next-PC select,
// load-use stall, branch/jump flush, data-memory freeze, and saturating stall/flush counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_i,
    input  logic             dmem_stall_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      pc_next_o,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOOT    = 2'd1,
        RUN     = 2'd2,
        MEMWAIT = 2'd3
    } state_t;

    state_t state, state_next;
    logic   load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    // $zero is never a real dependency, so a load into r0 cannot cause a hazard.
    assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    assign state_o = state;

    always_comb begin
        state_next    = state;
        pc_next_o     = RESET_VECTOR;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            state_next   = IDLE;
            ifid_flush_o = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    ifid_flush_o = 1'b1;
                    if (start_i) state_next = BOOT;
                end
                BOOT: begin
                    ifid_flush_o = 1'b1;
                    state_next   = RUN;
                end
                RUN, MEMWAIT: begin
                    // MEMWAIT decodes like RUN once memory is ready, so no cycle is lost on exit.
                    if (dmem_stall_i) begin
                        freeze_o     = 1'b1;
                        pc_stall_o   = 1'b1;
                        ifid_stall_o = 1'b1;
                        pc_next_o    = pc_i;
                        state_next   = MEMWAIT;
                    end else begin
                        state_next = RUN;
                        if (load_use) begin
                            pc_stall_o    = 1'b1;
                            ifid_stall_o  = 1'b1;
                            idex_bubble_o = 1'b1;
                            pc_next_o     = pc_i;
                        end else if (jump_i) begin
                            pc_next_o    = jump_target_i;
                            ifid_flush_o = 1'b1;
                        end else if (branch_taken_i) begin
                            pc_next_o    = branch_target_i;
                            ifid_flush_o = 1'b1;
                        end else begin
                            pc_next_o = pc_i + 32'd4;
                        end
                    end
                end
            endcase
            if (!start_i) state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state       <= state_next;
            stall_cnt_o <= sat_inc(stall_cnt_o, pc_stall_o && (state != IDLE));
            flush_cnt_o <= sat_inc(flush_cnt_o, ifid_flush_o && (state == RUN));
        end
    end

endmodule
